// File: rtl/uart_pkg.sv
// Shared definitions for the memory-dump UART transmitter.
// Contents: default baud divider, dump-controller state encoding and
// byte-serializer state encoding.
package uart_pkg;

  // 100 MHz / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_SEND_HI,
    ST_SEND_LO,
    ST_NEXT,
    ST_FIN
  } dump_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_mem_dump_tx_if.sv
// Control and BRAM read-port bundle of the memory-dump transmitter.
// Signals:
//   start, base_addr, word_count : dump request from the control logic
//   busy, done                   : dump status back to the control logic
//   mem_addr, mem_data           : BRAM I/O-port read address / read data
// Modports:
//   master : control logic + BRAM side
//   slave  : the dump engine
interface uart_mem_dump_tx_if;

  logic        start;
  logic [15:0] base_addr;
  logic [15:0] word_count;
  logic        busy;
  logic        done;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;

  modport master (
    output start, base_addr, word_count, mem_data,
    input  busy, done, mem_addr
  );

  modport slave (
    input  start, base_addr, word_count, mem_data,
    output busy, done, mem_addr
  );

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serializer.
// Ports:
//   clk_100, rst_n : clock, asynchronous active-low reset
//   tx_start       : load tx_data and begin a frame (honoured only when idle)
//   tx_data[7:0]   : byte to send, LSB first
//   tx_busy        : high from acceptance until the stop bit's last clock
//   tx             : serial line, idle high
//
// state    | meaning
// TX_IDLE  | line high, waiting for tx_start
// TX_START | start bit (0)
// TX_DATA  | eight data bits, LSB first
// TX_STOP  | stop bit (1)
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk_100,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t     state;
  logic [CW-1:0] bit_timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  // bit_timer counts down from CLKS_PER_BIT-1; each bit cell ends on terminal count.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= TX_IDLE;
      bit_timer <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (tx_start) begin
            shift     <= tx_data;
            tx        <= 1'b0;
            tx_busy   <= 1'b1;
            bit_timer <= BIT_LAST;
            state     <= TX_START;
          end
        end
        TX_START: begin
          if (bit_timer == '0) begin
            tx        <= shift[0];
            shift     <= {1'b0, shift[7:1]};
            bit_idx   <= 3'd0;
            bit_timer <= BIT_LAST;
            state     <= TX_DATA;
          end else begin
            bit_timer <= bit_timer - 1'b1;
          end
        end
        TX_DATA: begin
          if (bit_timer == '0) begin
            bit_timer <= BIT_LAST;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= TX_STOP;
            end else begin
              tx      <= shift[0];
              shift   <= {1'b0, shift[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_timer <= bit_timer - 1'b1;
          end
        end
        TX_STOP: begin
          if (bit_timer == '0) begin
            tx_busy <= 1'b0;
            state   <= TX_IDLE;
          end else begin
            bit_timer <= bit_timer - 1'b1;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_mem_dump_tx.sv
// Memory-dump UART transmitter: reads word_count 16-bit words from the BRAM
// I/O port starting at base_addr and sends each as two 8N1 frames, high
// byte first.
// Ports:
//   clk_100, rst_n : clock, asynchronous active-low reset
//   bus (slave)    : start/base_addr/word_count in, busy/done out,
//                    mem_addr out, mem_data in (1-cycle read latency)
//   tx             : UART serial out, idle high
//   led_tx         : mirrors busy
//
// state      | meaning
// ST_IDLE    | waiting for start; captures base address and word count
// ST_FETCH   | present the address counter on mem_addr
// ST_WAIT    | absorb BRAM latency, then latch the word and launch the high byte
// ST_SEND_HI | high byte on the line; launches the low byte when it ends
// ST_SEND_LO | low byte on the line
// ST_NEXT    | advance address, decrement remaining count
// ST_FIN     | done pulse, return to idle
module uart_mem_dump_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic              clk_100,
  input  logic              rst_n,
  uart_mem_dump_tx_if.slave bus,
  output logic              tx,
  output logic              led_tx
);

  dump_state_t state;
  logic [15:0] addr_cnt;
  logic [15:0] remain_cnt;
  logic [15:0] word;
  logic        wait_extra;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;

  // The serializer samples tx_data on the edge after tx_start is raised,
  // by which time the state already names the byte being sent.
  assign tx_data = (state == ST_SEND_LO) ? word[7:0] : word[15:8];
  assign led_tx  = bus.busy;

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      addr_cnt     <= '0;
      remain_cnt   <= '0;
      word         <= '0;
      wait_extra   <= 1'b0;
      tx_start     <= 1'b0;
      bus.mem_addr <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            addr_cnt   <= bus.base_addr;
            remain_cnt <= bus.word_count;
            bus.busy   <= 1'b1;
            wait_extra <= 1'b1;
            state      <= (bus.word_count == 16'd0) ? ST_FIN : ST_FETCH;
          end
        end
        ST_FETCH: begin
          bus.mem_addr <= addr_cnt;
          state        <= ST_WAIT;
        end
        // First word: mem_addr only changes in FETCH, so WAIT takes two
        // cycles. Later words were pre-addressed in NEXT, so one suffices.
        ST_WAIT: begin
          if (wait_extra) begin
            wait_extra <= 1'b0;
          end else begin
            word     <= bus.mem_data;
            tx_start <= 1'b1;
            state    <= ST_SEND_HI;
          end
        end
        // tx_busy is still low in the cycle tx_start is raised, so the
        // first cycle of each SEND state only drops tx_start.
        ST_SEND_HI: begin
          if (tx_start) begin
            tx_start <= 1'b0;
          end else if (!tx_busy) begin
            tx_start <= 1'b1;
            state    <= ST_SEND_LO;
          end
        end
        ST_SEND_LO: begin
          if (tx_start) begin
            tx_start <= 1'b0;
          end else if (!tx_busy) begin
            state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          addr_cnt   <= addr_cnt + 16'd1;
          remain_cnt <= remain_cnt - 16'd1;
          if (remain_cnt == 16'd1) begin
            // Raise done here to keep it within two cycles of the last stop bit.
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= ST_FIN;
          end else begin
            bus.mem_addr <= addr_cnt + 16'd1;
            state        <= ST_FETCH;
          end
        end
        ST_FIN: begin
          // Zero-count dumps arrive here with done low and pulse it now;
          // normal dumps already raised it in NEXT and this clears it.
          bus.done <= ~bus.done;
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk_100 (clk_100),
    .rst_n   (rst_n),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_busy (tx_busy),
    .tx      (tx)
  );

endmodule
